// File: rtl/lc3b_microsequencer.sv
// LC-3b microsequencer: state register, next-state logic, datapath strobes,
// memory wait-state timeout, illegal-opcode trap, HALT and retire counter.
module lc3b_microsequencer #(
  parameter int STATE_W      = 5,
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        ir,
  input  logic               n,
  input  logic               z,
  input  logic               p,
  input  logic               mem_ready,
  output logic [STATE_W-1:0] state_id,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_byte,
  output logic               ld_ir,
  output logic               ld_pc,
  output logic               ld_reg,
  output logic               ld_cc,
  output logic               ld_mar,
  output logic               ld_mdr,
  output logic [1:0]         pc_sel,
  output logic               dr_sel,
  output logic [1:0]         reg_src,
  output logic               halted,
  output logic [1:0]         err,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [3:0] {
    S_FETCH_REQ  = 4'd0,
    S_FETCH_WAIT = 4'd1,
    S_DECODE     = 4'd2,
    S_ALU        = 4'd3,
    S_BR         = 4'd4,
    S_JMP        = 4'd5,
    S_JSR        = 4'd6,
    S_LEA        = 4'd7,
    S_ADDR       = 4'd8,
    S_LD_WAIT    = 4'd9,
    S_LD_WB      = 4'd10,
    S_ST_WAIT    = 4'd11,
    S_TRAP       = 4'd12,
    S_TRAP_WAIT  = 4'd13,
    S_HALT       = 4'd14,
    S_ERR        = 4'd15
  } state_t;

  localparam int WC_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  state_t          state;
  state_t          nxt;
  logic [WC_W-1:0] wcnt;
  logic [1:0]      err_d;
  logic            retire;
  logic            in_wait;
  logic            timeout;
  logic            ben;
  logic [3:0]      op;
  logic            unused_ir;

  assign op        = ir[15:12];
  assign unused_ir = ir[8];
  assign ben       = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
  assign in_wait   = (state == S_FETCH_WAIT) || (state == S_LD_WAIT) ||
                     (state == S_ST_WAIT) || (state == S_TRAP_WAIT);
  assign timeout   = in_wait && !mem_ready &&
                     (wcnt == WC_W'(MEM_WAIT_MAX));
  assign state_id  = STATE_W'(state);
  assign halted    = (state == S_HALT) || (state == S_ERR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_FETCH_REQ;
      wcnt    <= '0;
      err     <= 2'd0;
      retired <= '0;
    end else begin
      state <= nxt;
      err   <= err_d;
      // cleared outside wait states, so every wait entry starts from zero
      wcnt  <= (in_wait && !mem_ready) ? wcnt + 1'b1 : '0;
      if (retire)
        retired <= retired + 1'b1;
    end
  end

  always_comb begin
    nxt      = state;
    err_d    = err;
    retire   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_byte = 1'b0;
    ld_ir    = 1'b0;
    ld_pc    = 1'b0;
    ld_reg   = 1'b0;
    ld_cc    = 1'b0;
    ld_mar   = 1'b0;
    ld_mdr   = 1'b0;
    pc_sel   = 2'd0;
    dr_sel   = 1'b0;
    reg_src  = 2'd0;
    unique case (state)
      S_FETCH_REQ: begin
        mem_req = 1'b1;
        nxt     = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ld_ir = 1'b1;
          ld_pc = 1'b1;
          nxt   = S_DECODE;
        end else if (timeout) begin
          nxt   = S_ERR;
          err_d = 2'd2;
        end
      end
      S_DECODE: begin
        case (op)
          4'b0001, 4'b0101,
          4'b1001, 4'b1101: nxt = S_ALU;
          4'b0000:          nxt = S_BR;
          4'b1100:          nxt = S_JMP;
          4'b0100:          nxt = S_JSR;
          4'b1110:          nxt = S_LEA;
          4'b0010, 4'b0110,
          4'b0011, 4'b0111: nxt = S_ADDR;
          4'b1111:          nxt = S_TRAP;
          default: begin
            nxt   = S_ERR;
            err_d = 2'd1;
          end
        endcase
      end
      S_ALU: begin
        ld_reg = 1'b1;
        ld_cc  = 1'b1;
        nxt    = S_FETCH_REQ;
        retire = 1'b1;
      end
      S_BR: begin
        ld_pc  = ben;
        pc_sel = 2'd1;
        nxt    = S_FETCH_REQ;
        retire = 1'b1;
      end
      S_JMP: begin
        ld_pc  = 1'b1;
        pc_sel = 2'd2;
        nxt    = S_FETCH_REQ;
        retire = 1'b1;
      end
      S_JSR: begin
        ld_reg  = 1'b1;
        dr_sel  = 1'b1;
        reg_src = 2'd2;
        ld_pc   = 1'b1;
        pc_sel  = ir[11] ? 2'd1 : 2'd2;
        nxt     = S_FETCH_REQ;
        retire  = 1'b1;
      end
      S_LEA: begin
        ld_reg  = 1'b1;
        reg_src = 2'd3;
        nxt     = S_FETCH_REQ;
        retire  = 1'b1;
      end
      S_ADDR: begin
        ld_mar = 1'b1;
        nxt    = ir[12] ? S_ST_WAIT : S_LD_WAIT;
      end
      S_LD_WAIT: begin
        mem_req  = 1'b1;
        mem_byte = ~ir[14];
        if (mem_ready) begin
          ld_mdr = 1'b1;
          nxt    = S_LD_WB;
        end else if (timeout) begin
          nxt   = S_ERR;
          err_d = 2'd2;
        end
      end
      S_LD_WB: begin
        ld_reg  = 1'b1;
        reg_src = 2'd1;
        ld_cc   = 1'b1;
        nxt     = S_FETCH_REQ;
        retire  = 1'b1;
      end
      S_ST_WAIT: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_byte = ~ir[14];
        if (mem_ready) begin
          nxt    = S_FETCH_REQ;
          retire = 1'b1;
        end else if (timeout) begin
          nxt   = S_ERR;
          err_d = 2'd2;
        end
      end
      S_TRAP: begin
        if (ir[7:0] == 8'h25) begin
          nxt   = S_HALT;
          err_d = 2'd0;
        end else begin
          ld_reg  = 1'b1;
          dr_sel  = 1'b1;
          reg_src = 2'd2;
          ld_mar  = 1'b1;
          nxt     = S_TRAP_WAIT;
        end
      end
      S_TRAP_WAIT: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ld_pc  = 1'b1;
          pc_sel = 2'd3;
          nxt    = S_FETCH_REQ;
          retire = 1'b1;
        end else if (timeout) begin
          nxt   = S_ERR;
          err_d = 2'd2;
        end
      end
      S_HALT, S_ERR: nxt = state;
      default:       nxt = S_ERR;
    endcase
  end

endmodule
